// File: rtl/painterengine_gpu_colorconvert_seq.sv
// Chunked pixel-format conversion sequencer: per chunk, one DMA reader burst into
// the converter FIFO followed by one DMA writer burst out of it.
module painterengine_gpu_colorconvert_seq #(
    parameter int unsigned BLOCK_PIXELS   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_start,
    input  logic        i_wire_abort,
    input  logic [1:0]  i_wire_mode,
    input  logic [31:0] i_wire_source_address,
    input  logic [31:0] i_wire_dest_address,
    input  logic [31:0] i_wire_pixel_count,
    output logic        o_wire_fifo_resetn,
    output logic [1:0]  o_wire_converter_mode,
    output logic        o_wire_dma_reader_resetn,
    output logic [31:0] o_wire_dma_reader_address,
    output logic [31:0] o_wire_dma_reader_length,
    input  logic        i_wire_dma_reader_done,
    input  logic        i_wire_dma_reader_error,
    output logic        o_wire_dma_writer_resetn,
    output logic [31:0] o_wire_dma_writer_address,
    output logic [31:0] o_wire_dma_writer_length,
    input  logic        i_wire_dma_writer_done,
    input  logic        i_wire_dma_writer_error,
    output logic        o_wire_busy,
    output logic [31:0] o_wire_progress,
    output logic [31:0] o_wire_state
);

    typedef enum logic [7:0] {
        ST_IDLE             = 8'h00,
        ST_CHECK            = 8'h01,
        ST_PUSH_PARAM       = 8'h02,
        ST_READ             = 8'h03,
        ST_READ_WAIT        = 8'h04,
        ST_WRITE            = 8'h05,
        ST_WRITE_WAIT       = 8'h06,
        ST_DONE             = 8'h08,
        ST_ALIGN_ERROR      = 8'h09,
        ST_DMA_READER_ERROR = 8'h0A,
        ST_DMA_WRITER_ERROR = 8'h0B,
        ST_TIMEOUT          = 8'h0C
    } state_t;

    localparam logic [31:0] BLOCK_LEN    = 32'(BLOCK_PIXELS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state, next_state;
    logic [1:0]  mode_q;
    logic [31:0] src_q, dst_q, count_q, progress_q, wait_cnt;
    logic [7:0]  chunk_q;
    logic        fifo_rn, rd_rn, wr_rn, busy_q;
    logic [31:0] rd_addr_q, rd_len_q, wr_addr_q, wr_len_q;

    logic [2:0]  src_bpp, dst_bpp;
    logic [31:0] remaining;
    logic [7:0]  chunk_next;
    logic [9:0]  rd_bytes, wr_bytes;
    logic        misaligned, terminal, launch, timeout_hit;

    always_comb begin
        src_bpp = 3'd4;
        dst_bpp = 3'd4;
        case (mode_q)
            2'd0:    dst_bpp = 3'd3;
            2'd1:    src_bpp = 3'd3;
            2'd2:    dst_bpp = 3'd2;
            default: ;
        endcase
    end

    assign misaligned  = (src_bpp == 3'd4 && src_q[1:0] != '0)
                       || (dst_bpp == 3'd4 && dst_q[1:0] != '0)
                       || (dst_bpp == 3'd2 && dst_q[0]);
    assign remaining   = count_q - progress_q;
    assign chunk_next  = (remaining < BLOCK_LEN) ? remaining[7:0] : BLOCK_LEN[7:0];
    assign rd_bytes    = 10'(chunk_next) * 10'(src_bpp);
    assign wr_bytes    = 10'(chunk_next) * 10'(dst_bpp);
    assign terminal    = (state == ST_DONE) || (state == ST_ALIGN_ERROR)
                       || (state == ST_DMA_READER_ERROR) || (state == ST_DMA_WRITER_ERROR)
                       || (state == ST_TIMEOUT);
    assign launch      = i_wire_start && !i_wire_abort && (state == ST_IDLE || terminal);
    // wait_cnt is 0 in the first wait cycle, so the limit is reached in cycle TIMEOUT_CYCLES
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) state <= ST_IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (launch) next_state = ST_CHECK;
            ST_CHECK:      next_state = misaligned ? ST_ALIGN_ERROR : ST_PUSH_PARAM;
            ST_PUSH_PARAM: next_state = (remaining == '0) ? ST_DONE : ST_READ;
            ST_READ:       next_state = ST_READ_WAIT;
            ST_READ_WAIT: begin
                if (i_wire_dma_reader_error)     next_state = ST_DMA_READER_ERROR;
                else if (i_wire_dma_reader_done) next_state = ST_WRITE;
                else if (timeout_hit)            next_state = ST_TIMEOUT;
            end
            ST_WRITE:      next_state = ST_WRITE_WAIT;
            ST_WRITE_WAIT: begin
                if (i_wire_dma_writer_error)     next_state = ST_DMA_WRITER_ERROR;
                else if (i_wire_dma_writer_done) next_state = ST_PUSH_PARAM;
                else if (timeout_hit)            next_state = ST_TIMEOUT;
            end
            ST_DONE, ST_ALIGN_ERROR, ST_DMA_READER_ERROR,
            ST_DMA_WRITER_ERROR, ST_TIMEOUT:
                if (launch) next_state = ST_CHECK;
            default:       next_state = ST_IDLE;
        endcase
        if (i_wire_abort) next_state = ST_IDLE;
    end

    // Outputs are registered from next_state so they line up with the state they belong to.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            mode_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            progress_q <= '0;
            chunk_q    <= '0;
            wait_cnt   <= '0;
            fifo_rn    <= 1'b0;
            rd_rn      <= 1'b0;
            wr_rn      <= 1'b0;
            busy_q     <= 1'b0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
        end else begin
            busy_q <= (next_state == ST_CHECK) || (next_state == ST_PUSH_PARAM)
                   || (next_state == ST_READ) || (next_state == ST_READ_WAIT)
                   || (next_state == ST_WRITE) || (next_state == ST_WRITE_WAIT);
            wait_cnt <= (next_state == state && (state == ST_READ_WAIT || state == ST_WRITE_WAIT))
                      ? wait_cnt + 32'd1 : '0;
            if (launch) begin
                mode_q     <= i_wire_mode;
                src_q      <= i_wire_source_address;
                dst_q      <= i_wire_dest_address;
                count_q    <= i_wire_pixel_count;
                progress_q <= '0;
            end
            if (state == ST_PUSH_PARAM && next_state == ST_READ) begin
                chunk_q   <= chunk_next;
                rd_addr_q <= src_q + progress_q * 32'(src_bpp);
                rd_len_q  <= {22'd0, rd_bytes};
                wr_addr_q <= dst_q + progress_q * 32'(dst_bpp);
                wr_len_q  <= {22'd0, wr_bytes};
            end
            if (state == ST_WRITE_WAIT && next_state == ST_PUSH_PARAM)
                progress_q <= progress_q + {24'd0, chunk_q};
            case (next_state)
                ST_IDLE, ST_PUSH_PARAM: begin
                    fifo_rn <= 1'b0;
                    rd_rn   <= 1'b0;
                    wr_rn   <= 1'b0;
                end
                ST_READ: begin
                    fifo_rn <= 1'b1;
                    rd_rn   <= 1'b1;
                    wr_rn   <= 1'b0;
                end
                ST_WRITE: begin
                    fifo_rn <= 1'b1;
                    rd_rn   <= 1'b0;
                    wr_rn   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_wire_fifo_resetn        = fifo_rn;
    assign o_wire_converter_mode     = mode_q;
    assign o_wire_dma_reader_resetn  = rd_rn;
    assign o_wire_dma_reader_address = rd_addr_q;
    assign o_wire_dma_reader_length  = rd_len_q;
    assign o_wire_dma_writer_resetn  = wr_rn;
    assign o_wire_dma_writer_address = wr_addr_q;
    assign o_wire_dma_writer_length  = wr_len_q;
    assign o_wire_busy               = busy_q;
    assign o_wire_progress           = progress_q;
    assign o_wire_state              = {24'd0, state};

endmodule

// File: tb/tb_painterengine_gpu_colorconvert_seq.sv
// Directed bench: DMA responder, chunk-list model of the job, per-cycle checker.
module tb_painterengine_gpu_colorconvert_seq;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]  mode = '0;
    logic [31:0] src = '0, dst = '0, cnt = '0;
    logic        rd_done = 1'b0, rd_err = 1'b0, wr_done = 1'b0;
    logic        wr_err = 1'b0;
    logic        fifo_rn, rd_rn, wr_rn, busy;
    logic [1:0]  conv_mode;
    logic [31:0] rd_addr, rd_len, wr_addr, wr_len, progress, state;
    logic [7:0]  st_now;

    int checks = 0, errors = 0;

    painterengine_gpu_colorconvert_seq #(.BLOCK_PIXELS(16), .TIMEOUT_CYCLES(8)) dut (
        .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_start(start), .i_wire_abort(abort),
        .i_wire_mode(mode), .i_wire_source_address(src), .i_wire_dest_address(dst),
        .i_wire_pixel_count(cnt), .o_wire_fifo_resetn(fifo_rn), .o_wire_converter_mode(conv_mode),
        .o_wire_dma_reader_resetn(rd_rn), .o_wire_dma_reader_address(rd_addr),
        .o_wire_dma_reader_length(rd_len), .i_wire_dma_reader_done(rd_done),
        .i_wire_dma_reader_error(rd_err), .o_wire_dma_writer_resetn(wr_rn),
        .o_wire_dma_writer_address(wr_addr), .o_wire_dma_writer_length(wr_len),
        .i_wire_dma_writer_done(wr_done), .i_wire_dma_writer_error(wr_err),
        .o_wire_busy(busy), .o_wire_progress(progress), .o_wire_state(state)
    );

    always #5 clk = ~clk;
    assign st_now = state[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- DMA responder ----------------
    int rd_delay = 2, wr_delay = 2, rd_err_chunk = 0;
    bit wr_never = 1'b0;
    int rd_cnt = 0, wr_cnt = 0, rd_bursts = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt = 0; wr_cnt = 0; rd_bursts = 0;
        end else begin
            if (st_now == 8'h01) rd_bursts = 0;
            if (rd_rn) begin
                rd_cnt++;
                if (rd_cnt == 1) rd_bursts++;
            end else rd_cnt = 0;
            wr_cnt = wr_rn ? wr_cnt + 1 : 0;
        end
        rd_done = rst_n && rd_rn && (rd_cnt == rd_delay);
        rd_err  = rd_done && (rd_bursts == rd_err_chunk);
        wr_done = rst_n && wr_rn && (wr_cnt == wr_delay) && !wr_never;
    end

    // ---------------- job model ----------------
    typedef struct {
        logic [31:0] ra, rl, wa, wl, prog;
    } chunk_t;

    logic [1:0]  j_mode = '0;
    logic [31:0] j_src = '0, j_dst = '0, j_count = '0;
    chunk_t      q[$];
    int          n_planned = 0, obs_n = 0;
    logic [31:0] obs_ra[8], obs_rl[8], obs_wa[8], obs_wl[8];
    bit          rose_seen = 1'b0;
    logic [7:0]  prev_st = '0;

    function automatic longint src_bpp(input logic [1:0] m);
        return (m == 2'd1) ? 3 : 4;
    endfunction
    function automatic longint dst_bpp(input logic [1:0] m);
        case (m)
            2'd0: return 3;
            2'd2: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic void build_job();
        longint sb = src_bpp(j_mode), db = dst_bpp(j_mode), c;
        bit ok = ((sb != 4) || (j_src % 4 == 0))
              && ((db == 4) ? (j_dst % 4 == 0) : (db == 2) ? (j_dst % 2 == 0) : 1'b1);
        chunk_t e;
        q.delete();
        if (ok) begin
            for (longint done = 0; done < longint'(j_count); done += c) begin
                c = (longint'(j_count) - done < 16) ? longint'(j_count) - done : 16;
                e.ra = 32'(longint'(j_src) + done * sb);
                e.rl = 32'(c * sb);
                e.wa = 32'(longint'(j_dst) + done * db);
                e.wl = 32'(c * db);
                e.prog = 32'(done);
                q.push_back(e);
            end
        end
        n_planned = q.size();
    endfunction

    always @(negedge clk) begin
        chunk_t c;
        if (!rst_n) prev_st = '0;
        else begin
            check("busy", {31'd0, busy}, {31'd0, (st_now >= 8'd1 && st_now <= 8'd6)});
            if (st_now == 8'h00 || st_now == 8'h02)
                check("resetn_low", {29'd0, fifo_rn, rd_rn, wr_rn}, 32'h0);
            if (st_now == 8'h03) check("resetn_read", {29'd0, fifo_rn, rd_rn, wr_rn}, 32'h6);
            if (st_now == 8'h05) check("resetn_write", {29'd0, fifo_rn, rd_rn, wr_rn}, 32'h5);
            if (st_now == 8'h01 && prev_st != 8'h01) begin
                build_job();
                obs_n = 0;
                rose_seen = 1'b0;
            end else if (fifo_rn || rd_rn || wr_rn) rose_seen = 1'b1;
            if (st_now == 8'h03 && prev_st != 8'h03) begin
                if (q.size() == 0) check("extra_chunk", 32'(obs_n + 1), 32'(n_planned));
                else begin
                    c = q.pop_front();
                    check("rd_addr", rd_addr, c.ra);
                    check("rd_len", rd_len, c.rl);
                    check("wr_addr", wr_addr, c.wa);
                    check("wr_len", wr_len, c.wl);
                    check("progress_at_read", progress, c.prog);
                end
                if (obs_n < 8) begin
                    obs_ra[obs_n] = rd_addr; obs_rl[obs_n] = rd_len;
                    obs_wa[obs_n] = wr_addr; obs_wl[obs_n] = wr_len;
                end
                obs_n++;
            end
            if (st_now == 8'h08 && prev_st != 8'h08) begin
                check("done_progress", progress, j_count);
                check("done_chunks_left", 32'(q.size()), 32'h0);
            end
            prev_st = st_now;
        end
    end

    // ---------------- directed sequence ----------------
    task automatic start_job(input logic [1:0] m, input logic [31:0] s, d, c);
        @(negedge clk);
        j_mode = m; j_src = s; j_dst = d; j_count = c;
        mode = m; src = s; dst = d; cnt = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_terminal();
        int i = 0;
        while (!(st_now >= 8'h08 && st_now <= 8'h0C) && i < 500) begin
            @(negedge clk);
            i++;
        end
        if (i >= 500) check("terminal_wait", 32'(st_now), 32'h08);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, 32'h0);
        check({tag, "_resetn"}, {29'd0, fifo_rn, rd_rn, wr_rn}, 32'h0);
        check({tag, "_rd"}, rd_addr | rd_len, 32'h0);
        check({tag, "_wr"}, wr_addr | wr_len, 32'h0);
        check({tag, "_progress"}, progress, 32'h0);
        check({tag, "_mode_busy"}, {29'd0, conv_mode, busy}, 32'h0);
    endtask

    initial begin
        int n_ww;
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // 40 pixels RGBA32->RGB24: chunks 16/16/8, with start-to-READ latency
        start_job(2'd0, 32'h1000, 32'h8000, 32'd40);
        check("lat_check", 32'(st_now), 32'h01);
        @(negedge clk);
        check("lat_push", 32'(st_now), 32'h02);
        @(negedge clk);
        check("lat_read", 32'(st_now), 32'h03);
        wait_terminal();
        check("a_state", state, 32'h08);
        check("a_progress", progress, 32'd40);
        check("a_chunks", 32'(obs_n), 32'd3);
        check("a_ra0", obs_ra[0], 32'h1000); check("a_rl0", obs_rl[0], 32'd64);
        check("a_ra1", obs_ra[1], 32'h1040); check("a_rl1", obs_rl[1], 32'd64);
        check("a_ra2", obs_ra[2], 32'h1080); check("a_rl2", obs_rl[2], 32'd32);
        check("a_wa0", obs_wa[0], 32'h8000); check("a_wl0", obs_wl[0], 32'd48);
        check("a_wa1", obs_wa[1], 32'h8030); check("a_wl1", obs_wl[1], 32'd48);
        check("a_wa2", obs_wa[2], 32'h8060); check("a_wl2", obs_wl[2], 32'd24);

        // RGB24 source on an odd address is legal
        start_job(2'd1, 32'h2001, 32'h4000, 32'd5);
        @(negedge clk);
        check("b_push", 32'(st_now), 32'h02);
        wait_terminal();
        check("b_state", state, 32'h08);
        check("b_mode", {30'd0, conv_mode}, 32'd1);
        check("b_rl", obs_rl[0], 32'd15);
        check("b_wl", obs_wl[0], 32'd20);

        // RGB565 destination must be 2-byte aligned
        start_job(2'd2, 32'h5000, 32'h3001, 32'd4);
        check("c_check", 32'(st_now), 32'h01);
        @(negedge clk);
        check("c_align", state, 32'h09);
        start_job(2'd2, 32'h5000, 32'h3002, 32'd4);
        wait_terminal();
        check("c_state", state, 32'h08);
        check("c_progress", progress, 32'd4);
        check("c_wa", obs_wa[0], 32'h3002);
        check("c_wl", obs_wl[0], 32'd8);

        // reader error with done in the same cycle on chunk 2
        rd_err_chunk = 2;
        start_job(2'd0, 32'h1000, 32'h8000, 32'd40);
        wait_terminal();
        rd_err_chunk = 0;
        check("d_state", state, 32'h0A);
        check("d_progress", progress, 32'd16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("d_resetn_hold", {29'd0, fifo_rn, rd_rn, wr_rn}, 32'h6);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("d_abort_state", state, 32'h00);
        check("d_abort_progress", progress, 32'd16);

        // writer never completes: timeout after 8 WRITE_WAIT cycles
        wr_never = 1'b1;
        start_job(2'd3, 32'h100, 32'h200, 32'd4);
        n_ww = 0;
        for (int i = 0; i < 200 && st_now != 8'h0C; i++) begin
            @(negedge clk);
            if (st_now == 8'h06) n_ww++;
        end
        wr_never = 1'b0;
        check("e_state", state, 32'h0C);
        check("e_ww_cycles", 32'(n_ww), 32'd8);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("e_abort_state", state, 32'h00);
        check("e_abort_resetn", {29'd0, fifo_rn, rd_rn, wr_rn}, 32'h0);

        // zero-length job
        start_job(2'd0, 32'h1000, 32'h8000, 32'd0);
        check("f_check", 32'(st_now), 32'h01);
        @(negedge clk);
        check("f_push", 32'(st_now), 32'h02);
        @(negedge clk);
        check("f_done", state, 32'h08);
        check("f_no_resetn_rise", {31'd0, rose_seen}, 32'h0);

        // asynchronous reset in the middle of READ_WAIT
        rd_delay = 5;
        start_job(2'd0, 32'h1000, 32'h8000, 32'd40);
        for (int i = 0; i < 50 && st_now != 8'h04; i++) @(negedge clk);
        check("g_in_read_wait", 32'(st_now), 32'h04);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        @(negedge clk);
        rst_n = 1'b1;
        rd_delay = 2;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
